// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, result-mux
// encodings, sequencer states and the control-vector payload.
package alu_ctrl_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned OSEL_W = 2;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OP_SLA  = 3'b010;
   localparam logic [OP_W-1:0] OP_SLL  = 3'b011;
   localparam logic [OP_W-1:0] OP_SRL  = 3'b100;
   localparam logic [OP_W-1:0] OP_LOGA = 3'b101;
   localparam logic [OP_W-1:0] OP_LOGB = 3'b110;
   localparam logic [OP_W-1:0] OP_ILL  = 3'b111;

   localparam logic [OSEL_W-1:0] OSEL_ADD = 2'd0;
   localparam logic [OSEL_W-1:0] OSEL_SHF = 2'd1;
   localparam logic [OSEL_W-1:0] OSEL_LOG = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // ALU datapath control vector
   typedef struct packed {
      logic              bsel;
      logic              cisel;
      logic [OSEL_W-1:0] osel;
      logic              shift_la;
      logic              shift_lr;
      logic              logical_op;
   } ctrl_t;

   function automatic logic is_shift(input logic [OP_W-1:0] op);
      return (op == OP_SLA) || (op == OP_SLL) || (op == OP_SRL);
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational opcode decoder: opcode to ALU control vector plus an
// illegal-opcode flag.
module alu_decode
   import alu_ctrl_pkg::*;
(
   input  logic [OP_W-1:0] op,
   output ctrl_t           ctrl,
   output logic            illegal
);

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      case (op)
         OP_ADD: begin
            ctrl.osel = OSEL_ADD;
         end
         OP_SUB: begin
            ctrl.bsel  = 1'b1;
            ctrl.cisel = 1'b1;
            ctrl.osel  = OSEL_ADD;
         end
         OP_SLA: begin
            ctrl.osel     = OSEL_SHF;
            ctrl.shift_la = 1'b1;
            ctrl.shift_lr = 1'b1;
         end
         OP_SLL: begin
            ctrl.osel     = OSEL_SHF;
            ctrl.shift_lr = 1'b1;
         end
         OP_SRL: begin
            ctrl.osel = OSEL_SHF;
         end
         OP_LOGA: begin
            ctrl.osel       = OSEL_LOG;
            ctrl.logical_op = 1'b1;
         end
         OP_LOGB: begin
            ctrl.osel = OSEL_LOG;
         end
         OP_ILL: begin
            illegal = 1'b1;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control sequencer: accepts one opcode and shift amount,
// drives the control vector for the required number of steps, then pulses done.
module alu_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [OP_W-1:0]    op,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               bsel,
   output logic               cisel,
   output logic [OSEL_W-1:0]  osel,
   output logic               shift_la,
   output logic               shift_lr,
   output logic               logical_op,
   output logic               step_en,
   output logic               done,
   output logic               err
);

   state_t             state;
   logic [SHAMT_W-1:0] cnt;
   ctrl_t              ctrl_q;

   ctrl_t              dec_ctrl;
   logic               dec_illegal;
   logic [SHAMT_W-1:0] load_cnt;

   // Decoded on the incoming opcode so the control register is loaded at accept
   alu_decode u_decode (
      .op      (op),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   always_comb begin
      load_cnt = is_shift(op) ? shamt : SHAMT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         ctrl_q    <= '0;
         req_ready <= 1'b1;
         step_en   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cnt       <= load_cnt;
                  req_ready <= 1'b0;
                  // Zero-length shifts and illegal opcodes skip the datapath entirely
                  if (dec_illegal || (load_cnt == '0)) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= dec_illegal;
                  end else begin
                     state   <= EXEC;
                     ctrl_q  <= dec_ctrl;
                     step_en <= 1'b1;
                  end
               end
            end
            EXEC: begin
               cnt <= cnt - SHAMT_W'(1);
               if (cnt == SHAMT_W'(1)) begin
                  state   <= DONE;
                  ctrl_q  <= '0;
                  step_en <= 1'b0;
                  done    <= 1'b1;
                  err     <= 1'b0;
               end
            end
            DONE: begin
               state     <= IDLE;
               done      <= 1'b0;
               err       <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               ctrl_q    <= '0;
               step_en   <= 1'b0;
               done      <= 1'b0;
               err       <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bsel       = ctrl_q.bsel;
   assign cisel      = ctrl_q.cisel;
   assign osel       = ctrl_q.osel;
   assign shift_la   = ctrl_q.shift_la;
   assign shift_lr   = ctrl_q.shift_lr;
   assign logical_op = ctrl_q.logical_op;

endmodule
